// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat round engine.
package baccarat_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PC1,
        DC1,
        PC2,
        DC2,
        EVAL,
        PC3,
        DC3,
        DONE
    } state_t;

    localparam int unsigned CARD_EMPTY = 0;
    localparam int unsigned CARD_A     = 1;
    localparam int unsigned CARD_NINE  = 9;
    localparam int unsigned CARD_K     = 13;

    // Pip value of a card code: A..9 keep their rank, everything else is worth 0.
    function automatic logic [3:0] card_value(input int unsigned code);
        logic [3:0] val;
        val = 4'd0;
        if ((code >= CARD_A) && (code <= CARD_NINE)) begin
            val = 4'(code);
        end
        return val;
    endfunction

    // Dealer third-card rule given the dealer two-card total and the player's third-card value.
    function automatic logic dealer_draws(input logic [3:0] dtotal, input logic [3:0] p3val);
        logic draw;
        draw = 1'b0;
        case (dtotal)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (p3val != 4'd8);
            4'd4:             draw = (p3val >= 4'd2) && (p3val <= 4'd7);
            4'd5:             draw = (p3val >= 4'd4) && (p3val <= 4'd7);
            4'd6:             draw = (p3val >= 4'd6) && (p3val <= 4'd7);
            default:          draw = 1'b0;
        endcase
        return draw;
    endfunction

endpackage

// File: rtl/scorehand_n.sv
// Combinational three-card hand scorer, result mod 10.
module scorehand_n
    import baccarat_pkg::*;
#(
    parameter int unsigned CARD_W = 4
) (
    input  logic [CARD_W-1:0] card1,
    input  logic [CARD_W-1:0] card2,
    input  logic [CARD_W-1:0] card3,
    output logic [3:0]        total_c
);

    logic [4:0] sum;

    // Sum of three pip values (max 27) folded back into 0..9.
    always_comb begin
        sum = 5'(card_value(32'(card1))) + 5'(card_value(32'(card2))) + 5'(card_value(32'(card3)));
        if (sum >= 5'd20) begin
            total_c = 4'(sum - 5'd20);
        end else if (sum >= 5'd10) begin
            total_c = 4'(sum - 5'd10);
        end else begin
            total_c = sum[3:0];
        end
    end

endmodule

// File: rtl/baccarat_round_ctrl.sv
// Baccarat round engine: deals cards, applies the third-card tableau, scores both
// hands and keeps saturating match tallies.
// Build option: define BACCARAT_NATURAL_EN to end a round at EVAL on a two-card 8 or 9.
module baccarat_round_ctrl
    import baccarat_pkg::*;
#(
    parameter int unsigned MATCH_LEN = 5,
    parameter int unsigned TALLY_W   = 4,
    parameter int unsigned CARD_W    = 4,
    localparam int unsigned RCNT_W   = $clog2(MATCH_LEN + 1)
) (
    input  logic                  slow_clock,
    input  logic                  resetb,
    input  logic                  step,
    input  logic [CARD_W-1:0]     card_in,
    input  logic                  new_match,
    output logic [3*CARD_W-1:0]   pcard,
    output logic [3*CARD_W-1:0]   dcard,
    output logic [3:0]            pscore,
    output logic [3:0]            dscore,
    output logic                  player_win,
    output logic                  dealer_win,
    output logic [TALLY_W-1:0]    p_wins,
    output logic [TALLY_W-1:0]    d_wins,
    output logic [TALLY_W-1:0]    ties,
    output logic [RCNT_W-1:0]     round_cnt,
    output logic                  match_done,
    output logic                  busy
);

    localparam logic [TALLY_W-1:0] TALLY_MAX  = '1;
    localparam logic [RCNT_W-1:0]  MATCH_LAST = RCNT_W'(MATCH_LEN);

    state_t                state_q, state_d;
    logic [3*CARD_W-1:0]   pcard_q, pcard_d;
    logic [3*CARD_W-1:0]   dcard_q, dcard_d;
    logic [3:0]            pscore_q, pscore_d;
    logic [3:0]            dscore_q, dscore_d;
    logic                  player_win_q, player_win_d;
    logic                  dealer_win_q, dealer_win_d;
    logic [TALLY_W-1:0]    p_wins_q, p_wins_d;
    logic [TALLY_W-1:0]    d_wins_q, d_wins_d;
    logic [TALLY_W-1:0]    ties_q, ties_d;
    logic [RCNT_W-1:0]     round_cnt_q, round_cnt_d;
    logic                  match_done_q, match_done_d;
    logic                  busy_q, busy_d;
    logic                  settle_q, settle_d;

    logic [3:0]            p_total_c;
    logic [3:0]            d_total_c;
    logic [3:0]            p3_val;
    logic [RCNT_W-1:0]     rc_inc;
    logic                  natural_hand;

    scorehand_n #(.CARD_W(CARD_W)) u_pscore (
        .card1   (pcard_q[CARD_W-1:0]),
        .card2   (pcard_q[2*CARD_W-1:CARD_W]),
        .card3   (pcard_q[3*CARD_W-1:2*CARD_W]),
        .total_c (p_total_c)
    );

    scorehand_n #(.CARD_W(CARD_W)) u_dscore (
        .card1   (dcard_q[CARD_W-1:0]),
        .card2   (dcard_q[2*CARD_W-1:CARD_W]),
        .card3   (dcard_q[3*CARD_W-1:2*CARD_W]),
        .total_c (d_total_c)
    );

    // Next-state, card latching, outcome and tally logic.
    always_comb begin
        state_d      = state_q;
        pcard_d      = pcard_q;
        dcard_d      = dcard_q;
        pscore_d     = p_total_c;
        dscore_d     = d_total_c;
        player_win_d = player_win_q;
        dealer_win_d = dealer_win_q;
        p_wins_d     = p_wins_q;
        d_wins_d     = d_wins_q;
        ties_d       = ties_q;
        round_cnt_d  = round_cnt_q;
        match_done_d = match_done_q;
        settle_d     = 1'b0;
        p3_val       = card_value(32'(card_in));
        rc_inc       = round_cnt_q + RCNT_W'(1);
        natural_hand = 1'b0;
`ifdef BACCARAT_NATURAL_EN
        natural_hand = (p_total_c >= 4'd8) || (d_total_c >= 4'd8);
`endif

        case (state_q)
            IDLE: begin
                if (step && !match_done_q) begin
                    pcard_d      = {3{CARD_W'(CARD_EMPTY)}};
                    dcard_d      = {3{CARD_W'(CARD_EMPTY)}};
                    pscore_d     = 4'd0;
                    dscore_d     = 4'd0;
                    player_win_d = 1'b0;
                    dealer_win_d = 1'b0;
                    state_d      = PC1;
                end
            end
            PC1: if (step) begin
                pcard_d[CARD_W-1:0] = card_in;
                state_d = DC1;
            end
            DC1: if (step) begin
                dcard_d[CARD_W-1:0] = card_in;
                state_d = PC2;
            end
            PC2: if (step) begin
                pcard_d[2*CARD_W-1:CARD_W] = card_in;
                state_d = DC2;
            end
            DC2: if (step) begin
                dcard_d[2*CARD_W-1:CARD_W] = card_in;
                state_d = EVAL;
            end
            EVAL: begin
                // Card registers already hold both two-card hands here.
                if (natural_hand) begin
                    state_d  = DONE;
                    settle_d = 1'b1;
                end else if (p_total_c <= 4'd5) begin
                    state_d = PC3;
                end else if (d_total_c <= 4'd5) begin
                    state_d = DC3;
                end else begin
                    state_d  = DONE;
                    settle_d = 1'b1;
                end
            end
            PC3: if (step) begin
                pcard_d[3*CARD_W-1:2*CARD_W] = card_in;
                if (dealer_draws(d_total_c, p3_val)) begin
                    state_d = DC3;
                end else begin
                    state_d  = DONE;
                    settle_d = 1'b1;
                end
            end
            DC3: if (step) begin
                dcard_d[3*CARD_W-1:2*CARD_W] = card_in;
                state_d  = DONE;
                settle_d = 1'b1;
            end
            DONE: begin
                if (settle_q) begin
                    // First DONE cycle: final cards are in, record the outcome once.
                    player_win_d = (p_total_c >= d_total_c);
                    dealer_win_d = (d_total_c >= p_total_c);
                    if (p_total_c == d_total_c) begin
                        if (ties_q != TALLY_MAX) ties_d = ties_q + TALLY_W'(1);
                    end else if (p_total_c > d_total_c) begin
                        if (p_wins_q != TALLY_MAX) p_wins_d = p_wins_q + TALLY_W'(1);
                    end else begin
                        if (d_wins_q != TALLY_MAX) d_wins_d = d_wins_q + TALLY_W'(1);
                    end
                    round_cnt_d  = rc_inc;
                    match_done_d = (rc_inc == MATCH_LAST);
                end else if (new_match) begin
                    p_wins_d     = '0;
                    d_wins_d     = '0;
                    ties_d       = '0;
                    round_cnt_d  = '0;
                    match_done_d = 1'b0;
                    state_d      = IDLE;
                end else if (step && !match_done_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = !((state_d == IDLE) || (state_d == DONE));
    end

    // State and output registers.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= IDLE;
            pcard_q      <= '0;
            dcard_q      <= '0;
            pscore_q     <= 4'd0;
            dscore_q     <= 4'd0;
            player_win_q <= 1'b0;
            dealer_win_q <= 1'b0;
            p_wins_q     <= '0;
            d_wins_q     <= '0;
            ties_q       <= '0;
            round_cnt_q  <= '0;
            match_done_q <= 1'b0;
            busy_q       <= 1'b0;
            settle_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcard_q      <= pcard_d;
            dcard_q      <= dcard_d;
            pscore_q     <= pscore_d;
            dscore_q     <= dscore_d;
            player_win_q <= player_win_d;
            dealer_win_q <= dealer_win_d;
            p_wins_q     <= p_wins_d;
            d_wins_q     <= d_wins_d;
            ties_q       <= ties_d;
            round_cnt_q  <= round_cnt_d;
            match_done_q <= match_done_d;
            busy_q       <= busy_d;
            settle_q     <= settle_d;
        end
    end

    assign pcard      = pcard_q;
    assign dcard      = dcard_q;
    assign pscore     = pscore_q;
    assign dscore     = dscore_q;
    assign player_win = player_win_q;
    assign dealer_win = dealer_win_q;
    assign p_wins     = p_wins_q;
    assign d_wins     = d_wins_q;
    assign ties       = ties_q;
    assign round_cnt  = round_cnt_q;
    assign match_done = match_done_q;
    assign busy       = busy_q;

endmodule
